// File: rtl/min_sec_counter_if.sv
// Button and display bundle for the minutes:seconds stopwatch.
// Buttons are plain levels, sampled every clock; there is no valid/ready handshake.
// The counter acts on the 0->1 transition of a button level. Display outputs are
// registered and valid in every cycle after reset.
interface min_sec_counter_if;
  logic       start_i;
  logic       clr_i;
  logic       lap_i;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic       running_o;
  logic       wrap_o;
  logic       lapped_o;
  logic [1:0] state_dbg;

  modport master (
    output start_i, clr_i, lap_i,
    input  min_o, sec_o, running_o, wrap_o, lapped_o, state_dbg
  );

  modport slave (
    input  start_i, clr_i, lap_i,
    output min_o, sec_o, running_o, wrap_o, lapped_o, state_dbg
  );
endinterface

// File: rtl/min_sec_counter.sv
// Minutes:seconds stopwatch with start/pause toggle, clear and an optional lap freeze.
// Define COUNTER_LAP_EN to compile in the lap-freeze display feature.
module min_sec_counter #(
  parameter int unsigned DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  min_sec_counter_if.slave bus
);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;

`ifdef COUNTER_LAP_EN
  localparam int unsigned NB = 3;
  logic [NB-1:0] btn;
  assign btn = {bus.lap_i, bus.clr_i, bus.start_i};
`else
  localparam int unsigned NB = 2;
  logic [NB-1:0] btn;
  logic          unused_lap;
  assign btn        = {bus.clr_i, bus.start_i};
  assign unused_lap = bus.lap_i;
`endif

  // btn_blk masks a button that was already high when reset was applied,
  // so it must be seen low once before its next rise counts.
  logic [NB-1:0] btn_q, btn_blk, rise;
  logic          start_rise, clr_rise;

  assign rise       = btn & ~btn_q & ~btn_blk;
  assign start_rise = rise[0];
  assign clr_rise   = rise[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q   <= '0;
      btn_blk <= btn;
    end else begin
      btn_q   <= btn;
      btn_blk <= btn_blk & btn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    if (clr_rise) begin
      state_d = IDLE;
    end else if (start_rise) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic          wrap_q, wrap_d, tick;

  // The prescaler advances on every edge that starts in RUN, including the
  // edge that pauses, so a tick landing on a pause edge is still counted.
  always_comb begin : count_next
    tick   = (state_q == RUN) && (pre_q == PRE_LAST);
    pre_d  = pre_q;
    sec_d  = sec_q;
    min_d  = min_q;
    wrap_d = 1'b0;
    if (state_q == RUN) pre_d = tick ? '0 : pre_q + PW'(1);
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          wrap_d = 1'b1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (clr_rise) begin
      pre_d  = '0;
      sec_d  = 6'd0;
      min_d  = 6'd0;
      wrap_d = 1'b0;
    end
  end

  logic lapped_q, lapped_d;

`ifdef COUNTER_LAP_EN
  always_comb begin : lap_next
    lapped_d = lapped_q;
    if (clr_rise)                          lapped_d = 1'b0;
    else if (rise[2] && (state_q != IDLE)) lapped_d = ~lapped_q;
  end
`else
  assign lapped_d = 1'b0;
`endif

  // While not frozen the display registers load the same next value as the
  // count, so they always equal it; freezing simply stops the load.
  logic [5:0] min_disp, sec_disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      sec_q    <= 6'd0;
      min_q    <= 6'd0;
      wrap_q   <= 1'b0;
      lapped_q <= 1'b0;
      min_disp <= 6'd0;
      sec_disp <= 6'd0;
    end else begin
      pre_q    <= pre_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      wrap_q   <= wrap_d;
      lapped_q <= lapped_d;
      if (!lapped_d) begin
        min_disp <= min_d;
        sec_disp <= sec_d;
      end
    end
  end

  assign bus.min_o     = min_disp;
  assign bus.sec_o     = sec_disp;
  assign bus.running_o = (state_q == RUN);
  assign bus.wrap_o    = wrap_q;
  assign bus.lapped_o  = lapped_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_min_sec_counter.sv
// Self-checking bench for min_sec_counter (DIV=4): directed scenarios, then random
// button activity, all compared cycle by cycle against an elapsed-time model.
`timescale 1ns/1ps
module tb_min_sec_counter;
  localparam int unsigned DIV  = 4;
  localparam longint      HOUR = 3600 * DIV;
`ifdef COUNTER_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  min_sec_counter_if bus();

  min_sec_counter #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is tracked as the number of clock edges spent running; the display is
  // derived from that with plain division, and a rollover is every full hour.
  longint m_cycles;
  bit     m_active, m_running, m_frozen, m_wrap, m_valid;
  int     m_frozen_secs;
  bit     b_start, b_clr, b_lap;

  function automatic int count_secs();
    return int'((m_cycles / DIV) % 3600);
  endfunction

  task automatic model_edge();
    bit rs, rc, rl, was_active;
    int old_secs, d;
    if (rst) begin
      m_cycles  = 0;
      m_active  = 0;
      m_running = 0;
      m_frozen  = 0;
      m_wrap    = 0;
      m_valid   = 1;
      b_start   = bus.start_i;
      b_clr     = bus.clr_i;
      b_lap     = bus.lap_i;
    end else begin
      rs = bus.start_i && !b_start;
      rc = bus.clr_i   && !b_clr;
      rl = bus.lap_i   && !b_lap;
      b_start = bus.start_i;
      b_clr   = bus.clr_i;
      b_lap   = bus.lap_i;
      was_active = m_active;
      old_secs   = count_secs();
      m_wrap     = 0;
      if (rc) begin
        m_cycles  = 0;
        m_active  = 0;
        m_running = 0;
        m_frozen  = 0;
      end else begin
        if (m_running) begin
          m_cycles++;
          m_wrap = (m_cycles % HOUR == 0);
        end
        if (rs) begin
          if (!m_active) begin
            m_active  = 1;
            m_running = 1;
          end else begin
            m_running = !m_running;
          end
        end
        if (LAP && rl && was_active) begin
          if (!m_frozen) begin
            m_frozen      = 1;
            m_frozen_secs = old_secs;
          end else begin
            m_frozen = 0;
          end
        end
      end
    end
    if (m_valid) begin
      d = m_frozen ? m_frozen_secs : count_secs();
      exp_q.push_back({m_running, m_wrap, m_frozen, 6'(d / 60), 6'(d % 60)});
    end
  endtask

  task automatic check_outputs();
    logic [14:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("running", bus.running_o, e[14]);
    chk("wrap",    bus.wrap_o,    e[13]);
    chk("lapped",  bus.lapped_o,  e[12]);
    chk("min",     bus.min_o,     e[11:6]);
    chk("sec",     bus.sec_o,     e[5:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick1();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  // 0 = start, 1 = clr, 2 = lap; one-cycle pulse acted on at the next edge
  task automatic press(input int b);
    case (b)
      0: bus.start_i = 1'b1;
      1: bus.clr_i   = 1'b1;
      default: bus.lap_i = 1'b1;
    endcase
    tick1();
    bus.start_i = 1'b0;
    bus.clr_i   = 1'b0;
    bus.lap_i   = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_valid = 0;
    bus.start_i = 1'b0;
    bus.clr_i   = 1'b0;
    bus.lap_i   = 1'b0;
    rst = 1'b1;
    tick1();
    tick1();
    chk("rst_min", bus.min_o, 0);
    chk("rst_sec", bus.sec_o, 0);
    chk("rst_running", bus.running_o, 0);
    chk("rst_wrap", bus.wrap_o, 0);
    chk("rst_lapped", bus.lapped_o, 0);
    rst = 1'b0;
    tick1();

    // one minute of run time; first tick lands 4 edges after RUN entry
    press(0);
    chk("run_entry", bus.running_o, 1);
    cycles(3);
    chk("pre_first_tick_sec", bus.sec_o, 0);
    cycles(1);
    chk("first_tick_sec", bus.sec_o, 1);
    cycles(236);
    chk("one_min_min", bus.min_o, 1);
    chk("one_min_sec", bus.sec_o, 0);
    chk("one_min_running", bus.running_o, 1);

    // pause keeps the partial second
    press(1);
    chk("clr_sec", bus.sec_o, 0);
    chk("clr_running", bus.running_o, 0);
    press(0);
    cycles(1);
    press(0);
    chk("pause_running", bus.running_o, 0);
    cycles(20);
    chk("pause_sec", bus.sec_o, 0);
    press(0);
    chk("resume_running", bus.running_o, 1);
    cycles(1);
    chk("resume_pre_tick", bus.sec_o, 0);
    cycles(1);
    chk("resume_tick", bus.sec_o, 1);

    // clr beats start in the same cycle
    cycles(24);
    chk("at_7_sec", bus.sec_o, 7);
    bus.start_i = 1'b1;
    bus.clr_i   = 1'b1;
    tick1();
    bus.start_i = 1'b0;
    bus.clr_i   = 1'b0;
    chk("clr_start_running", bus.running_o, 0);
    chk("clr_start_sec", bus.sec_o, 0);
    chk("clr_start_min", bus.min_o, 0);
    cycles(5);
    chk("idle_hold_sec", bus.sec_o, 0);
    press(2);
    chk("idle_lap_ignored", bus.lapped_o, 0);

`ifdef COUNTER_LAP_EN
    press(0);
    cycles(20);
    press(2);
    chk("lap_freeze_flag", bus.lapped_o, 1);
    chk("lap_freeze_sec", bus.sec_o, 5);
    cycles(47);
    chk("lap_hold_sec", bus.sec_o, 5);
    chk("lap_hold_flag", bus.lapped_o, 1);
    press(2);
    chk("lap_release_sec", bus.sec_o, 17);
    chk("lap_release_flag", bus.lapped_o, 0);
    press(1);
`endif

    // rollover 59:59 -> 00:00 with a single wrap pulse
    press(0);
    cycles(3598 * DIV);
    chk("pre_wrap_min", bus.min_o, 59);
    chk("pre_wrap_sec", bus.sec_o, 58);
    cycles(DIV);
    chk("last_sec", bus.sec_o, 59);
    chk("last_wrap", bus.wrap_o, 0);
    cycles(DIV);
    chk("wrap_pulse", bus.wrap_o, 1);
    chk("wrap_min", bus.min_o, 0);
    chk("wrap_sec", bus.sec_o, 0);
    cycles(1);
    chk("wrap_one_cycle", bus.wrap_o, 0);

    // start held through reset release is not a rise
    bus.start_i = 1'b1;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    chk("held_start_idle", bus.running_o, 0);
    bus.start_i = 1'b0;
    tick1();
    chk("held_start_fall", bus.running_o, 0);
    bus.start_i = 1'b1;
    tick1();
    chk("held_start_rerise", bus.running_o, 1);
    bus.start_i = 1'b0;

    // random button activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.start_i = ~bus.start_i;
      if ($urandom_range(0, 79) == 0) bus.clr_i   = ~bus.clr_i;
      if ($urandom_range(0, 19) == 0) bus.lap_i   = ~bus.lap_i;
      rst = ($urandom_range(0, 499) == 0);
      tick1();
    end
    rst = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 SHALL have parameter DIV, default 100000000, clk cycles per one-second tick (legal range 2..2^27).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  level button; each rising edge toggles run/pause.
REQ-005 SHALL have port clr_i  input  1  level button; rising edge clears count and stops.
REQ-006 SHALL have port lap_i  input  1  level button; rising edge toggles display freeze (LAP_EN only).
REQ-007 SHALL have port min_o  output  6  displayed minutes, 0..59, registered.
REQ-008 SHALL have port sec_o  output  6  displayed seconds, 0..59, registered.
REQ-009 SHALL have port running_o  output  1  high while in RUN.
REQ-010 SHALL have port wrap_o  output  1  one-cycle pulse on 59:59 -> 00:00 rollover.
REQ-011 SHALL have port lapped_o  output  1  high while display is frozen.

Function
REQ-012 SHALL register each button once per cycle and detect a rising edge as current high and previous-sampled low; an edge is acted on at the same clock edge on which it is detected, so outputs change one cycle after the input rises.
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE: start edge IDLE->RUN, RUN->PAUSE, PAUSE->RUN; clr edge any->IDLE.
REQ-014 SHALL give clr edge priority over start and lap edges in the same cycle.
REQ-015 SHALL, in IDLE, hold internal count at 00:00 and prescaler at 0.
REQ-016 SHALL advance the prescaler only in RUN, counting 0..DIV-1; reaching DIV-1 generates a tick and wraps to 0.
REQ-017 SHALL hold prescaler value in PAUSE so resumption continues the partial second.
REQ-018 SHALL, on tick, increment sec; at sec 59 set sec 0 and increment min; at 59:59 set 00:00 and pulse wrap_o high for exactly that cycle.
REQ-019 SHALL apply a tick coinciding with a RUN->PAUSE start edge before pausing.
REQ-020 SHALL never present min_o or sec_o values above 59.
REQ-021 SHALL drive running_o high exactly when state is RUN.
REQ-022 SHALL, with lapped_o low, drive min_o/sec_o equal to the internal count.

Reset
REQ-023 SHALL, on rst high at a clock edge, force state IDLE, count 00:00, prescaler 0, all button history 0, min_o=0, sec_o=0, running_o=0, wrap_o=0, lapped_o=0.
REQ-024 SHALL treat a button held high through reset release as not edged until it falls and rises again.
REQ-025 SHALL abort any operation in progress on reset, mid-second included; no tick or wrap pulse is emitted in the reset cycle.

Configuration
REQ-026 SHALL use macro COUNTER_LAP_EN to compile in the lap-freeze feature.
REQ-027 SHALL, with COUNTER_LAP_EN defined: lap edge in RUN or PAUSE toggles freeze; freezing captures the current count into min_o/sec_o and sets lapped_o; internal counting continues unaffected; second lap edge releases freeze and outputs track count next cycle; lap edge in IDLE ignored; clr edge releases freeze.
REQ-028 SHALL, with COUNTER_LAP_EN undefined: lap_i port present but ignored, lapped_o tied 0, outputs always track count.

Verification (DIV=4)
REQ-029 SHALL cover: rst, start_i rise, hold 240 clk -> running_o=1, min_o=1, sec_o=0 after 60 ticks; first tick 4 cycles after RUN entered.
REQ-030 SHALL cover: preload via run to 59:58, 2 ticks -> 59:59 then 00:00 with wrap_o high exactly one cycle.
REQ-031 SHALL cover: start, 2 cycles, start edge (PAUSE) for 20 cycles, start edge -> next tick after 2 further cycles; sec_o unchanged during pause.
REQ-032 SHALL cover: start_i and clr_i rise same cycle while RUN at 00:07 -> IDLE, 00:00, running_o=0.
REQ-033 SHALL cover (COUNTER_LAP_EN): lap at 00:05, run 12 ticks -> outputs hold 00:05, lapped_o=1; lap again -> outputs 00:17 next cycle.
REQ-034 SHALL cover: rst asserted with start_i held high, release rst -> state stays IDLE until start_i falls and rises.
